// File: rtl/out_pass4_capture_if.sv
// Bundle for the output-pass capture block: nibble taps, trigger setup,
// readback FIFO handshake and status.
interface out_pass4_capture_if;
    logic        I0;
    logic        I1;
    logic        I2;
    logic        I3;
    logic        arm;
    logic [3:0]  trig_value;
    logic [3:0]  trig_mask;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        rd_ready;
    logic [1:0]  state;
    logic        done;
    logic        overflow;

    modport master (
        output I0, I1, I2, I3, arm, trig_value, trig_mask, rd_ready,
        input  rd_data, rd_valid, state, done, overflow
    );

    modport slave (
        input  I0, I1, I2, I3, arm, trig_value, trig_mask, rd_ready,
        output rd_data, rd_valid, state, done, overflow
    );
endinterface

// File: rtl/out_pass4_capture.sv
// Captures the output-pass nibble stream into 32-bit words after a masked
// trigger and buffers them in a small readback FIFO.
module out_pass4_capture #(
    parameter int CAPTURE_WORDS = 16,
    parameter int FIFO_DEPTH    = 4
) (
    input logic                UserCLK,
    input logic                resetn,
    out_pass4_capture_if.slave bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [15:0] WORDS_C = 16'(CAPTURE_WORDS);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } state_e;

    state_e        state_q, state_d;
    logic [2:0]    nib_idx_q, nib_idx_d;
    logic [31:0]   word_q, word_d;
    logic [15:0]   word_cnt_q, word_cnt_d;
    logic          overflow_q, overflow_d;
    logic          done_q;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          rd_valid_q;
    logic [31:0]   rd_data_q, rd_data_d;
    logic [31:0]   mem_q [FIFO_DEPTH];

    logic [3:0]    nib_s;
    logic          hit_s;
    logic          wr_req_s;
    logic [31:0]   cur_word_s;
    logic          full_s;
    logic          pop_s;
    logic          push_s;
    logic [AW-1:0] rd_ptr_inc_s;

    // Inputs are used unregistered so the hitting nibble lands in word 0.
    assign nib_s        = {bus.I3, bus.I2, bus.I1, bus.I0};
    assign hit_s        = ((nib_s ^ bus.trig_value) & bus.trig_mask) == 4'd0;
    assign full_s       = (cnt_q == DEPTH_C);
    assign pop_s        = (cnt_q != '0) && bus.rd_ready;
    assign push_s       = wr_req_s && (!full_s || pop_s);
    assign rd_ptr_inc_s = rd_ptr_q + AW'(1);

    // Capture FSM next state, nibble assembly and overflow tracking.
    always_comb begin
        state_d    = state_q;
        nib_idx_d  = nib_idx_q;
        word_d     = word_q;
        word_cnt_d = word_cnt_q;
        overflow_d = overflow_q;
        wr_req_s   = 1'b0;
        cur_word_s = word_q;
        cur_word_s[{nib_idx_q, 2'b00} +: 4] = nib_s;
        case (state_q)
            ST_IDLE: begin
                if (bus.arm) state_d = ST_ARMED;
                else         state_d = ST_IDLE;
            end
            ST_ARMED: begin
                if (hit_s) begin
                    word_d    = {28'd0, nib_s};
                    nib_idx_d = 3'd1;
                    state_d   = ST_CAPTURE;
                end else begin
                    state_d   = ST_ARMED;
                end
            end
            ST_CAPTURE: begin
                word_d = cur_word_s;
                if (nib_idx_q == 3'd7) begin
                    wr_req_s   = 1'b1;
                    nib_idx_d  = 3'd0;
                    word_cnt_d = word_cnt_q + 16'd1;
                    if (word_cnt_q + 16'd1 == WORDS_C) state_d = ST_DONE;
                    else                               state_d = ST_CAPTURE;
                end else begin
                    nib_idx_d = nib_idx_q + 3'd1;
                end
            end
            ST_DONE: begin
                if (bus.arm) begin
                    state_d    = ST_ARMED;
                    overflow_d = 1'b0;
                    word_cnt_d = 16'd0;
                    nib_idx_d  = 3'd0;
                end else begin
                    state_d    = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // A word is dropped only when full and nothing leaves on the same edge.
        if (wr_req_s && full_s && !pop_s) overflow_d = 1'b1;
        else                              overflow_d = overflow_d;
    end

    // FIFO pointer, occupancy and registered head-word update.
    always_comb begin
        rd_ptr_d  = pop_s  ? rd_ptr_inc_s : rd_ptr_q;
        wr_ptr_d  = push_s ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_data_d = rd_data_q;
        case ({push_s, pop_s})
            2'b10:   cnt_d = cnt_q + (AW+1)'(1);
            2'b01:   cnt_d = cnt_q - (AW+1)'(1);
            default: cnt_d = cnt_q;
        endcase
        if (cnt_q == '0) begin
            if (push_s) rd_data_d = cur_word_s;
            else        rd_data_d = rd_data_q;
        end else if (pop_s) begin
            if (cnt_q != (AW+1)'(1)) rd_data_d = mem_q[rd_ptr_inc_s];
            else if (push_s)         rd_data_d = cur_word_s;
            else                     rd_data_d = rd_data_q;
        end else begin
            rd_data_d = rd_data_q;
        end
    end

    // State and status registers with synchronous active-low reset.
    always_ff @(posedge UserCLK) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            nib_idx_q  <= 3'd0;
            word_q     <= 32'd0;
            word_cnt_q <= 16'd0;
            overflow_q <= 1'b0;
            done_q     <= 1'b0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            cnt_q      <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= 32'd0;
        end else begin
            state_q    <= state_d;
            nib_idx_q  <= nib_idx_d;
            word_q     <= word_d;
            word_cnt_q <= word_cnt_d;
            overflow_q <= overflow_d;
            done_q     <= (state_d == ST_DONE);
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            cnt_q      <= cnt_d;
            rd_valid_q <= (cnt_d != '0);
            rd_data_q  <= rd_data_d;
        end
    end

    // FIFO storage; contents are only observable through rd_data_q.
    always_ff @(posedge UserCLK) begin
        if (push_s) mem_q[wr_ptr_q] <= cur_word_s;
        else        mem_q[wr_ptr_q] <= mem_q[wr_ptr_q];
    end

    assign bus.state    = state_q;
    assign bus.done     = done_q;
    assign bus.overflow = overflow_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.rd_data  = rd_data_q;
endmodule

// File: tb/tb_out_pass4_capture.sv
// Random and directed stimulus for out_pass4_capture, checked every cycle
// against a queue-based reference model.
module tb_out_pass4_capture;
    localparam int CW    = 6;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic resetn;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    out_pass4_capture_if bus_if ();

    out_pass4_capture #(.CAPTURE_WORDS(CW), .FIFO_DEPTH(DEPTH)) dut (
        .UserCLK (clk),
        .resetn  (resetn),
        .bus     (bus_if)
    );

    // Reference model: mode 0..3, nibbles of the current word, FIFO queue.
    int          m_mode;
    int          m_nibs[$];
    logic [31:0] m_fifo[$];
    int          m_words;
    bit          m_ovf;
    logic [3:0]  nib_v;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic set_in(input bit a, input logic [3:0] n, input bit rdy);
        bus_if.arm      = a;
        {bus_if.I3, bus_if.I2, bus_if.I1, bus_if.I0} = n;
        nib_v           = n;
        bus_if.rd_ready = rdy;
    endtask

    task automatic model_step();
        logic [31:0] w;
        bit wr, pop, was_full;
        wr = 1'b0;
        w  = 32'd0;
        if (!resetn) begin
            m_mode = 0; m_nibs.delete(); m_fifo.delete(); m_words = 0; m_ovf = 1'b0;
            return;
        end
        pop      = (m_fifo.size() != 0) && bus_if.rd_ready;
        was_full = (m_fifo.size() == DEPTH);
        case (m_mode)
            0: if (bus_if.arm) m_mode = 1;
            1: if (((nib_v ^ bus_if.trig_value) & bus_if.trig_mask) == 4'd0) begin
                   m_nibs.delete(); m_nibs.push_back(int'(nib_v)); m_mode = 2;
               end
            2: begin
                   m_nibs.push_back(int'(nib_v));
                   if (m_nibs.size() == 8) begin
                       for (int k = 0; k < 8; k++) w = w + (32'(m_nibs[k]) << (4 * k));
                       wr = 1'b1;
                       m_nibs.delete();
                       m_words++;
                       if (m_words == CW) m_mode = 3;
                   end
               end
            default: if (bus_if.arm) begin
                   m_mode = 1; m_ovf = 1'b0; m_words = 0; m_nibs.delete();
               end
        endcase
        if (pop) void'(m_fifo.pop_front());
        if (wr) begin
            if (was_full && !pop) m_ovf = 1'b1;
            else                  m_fifo.push_back(w);
        end
    endtask

    task automatic compare_all();
        check("state",    {30'd0, bus_if.state},    32'(m_mode));
        check("done",     {31'd0, bus_if.done},     {31'd0, m_mode == 3});
        check("overflow", {31'd0, bus_if.overflow}, {31'd0, m_ovf});
        check("rd_valid", {31'd0, bus_if.rd_valid}, {31'd0, m_fifo.size() != 0});
        if (m_fifo.size() != 0) check("rd_data", bus_if.rd_data, m_fifo[0]);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic run_to_done(input bit rnd_rdy);
        for (int i = 0; i < 400 && m_mode != 3; i++) begin
            set_in(1'b0, 4'($urandom), rnd_rdy ? 1'($urandom) : 1'b0);
            tick();
        end
        check("reach_done", {31'd0, bus_if.done}, 32'd1);
    endtask

    task automatic drain();
        for (int i = 0; i < 2 * DEPTH; i++) begin
            set_in(1'b0, 4'($urandom), 1'b1);
            tick();
        end
        check("drained", {31'd0, bus_if.rd_valid}, 32'd0);
    endtask

    initial begin
        logic [3:0] seq[4];
        seq[0] = 4'h3; seq[1] = 4'h5; seq[2] = 4'hA; seq[3] = 4'hB;
        resetn = 1'b0;
        bus_if.trig_mask  = 4'h0;
        bus_if.trig_value = 4'h0;
        set_in(1'b0, 4'h0, 1'b0);
        tick();
        tick();
        check("rst_rd_data", bus_if.rd_data, 32'h0);
        resetn = 1'b1;

        // Mask 0: trigger on the first armed cycle, nibbles 0..7 form one word.
        set_in(1'b1, 4'h0, 1'b0);
        tick();
        for (int k = 0; k < 8; k++) begin
            set_in(1'b0, 4'(k), 1'b0);
            tick();
        end
        check("word0", bus_if.rd_data, 32'h76543210);
        check("word0_valid", {31'd0, bus_if.rd_valid}, 32'd1);

        // Six words into a four-deep FIFO with no reads: two are dropped.
        run_to_done(1'b0);
        check("ovf_after_run", {31'd0, bus_if.overflow}, 32'd1);

        // Re-arm from DONE keeps the FIFO contents.
        set_in(1'b1, 4'h0, 1'b0);
        tick();
        check("rearm_state", {30'd0, bus_if.state}, 32'd1);
        check("rearm_done", {31'd0, bus_if.done}, 32'd0);
        check("rearm_ovf", {31'd0, bus_if.overflow}, 32'd0);
        check("rearm_head", bus_if.rd_data, 32'h76543210);

        // Write onto a full FIFO while popping on the same edge.
        for (int k = 0; k < 8; k++) begin
            set_in(1'b0, 4'($urandom), k == 7);
            tick();
        end
        check("full_pop_ovf", {31'd0, bus_if.overflow}, 32'd0);
        check("full_pop_valid", {31'd0, bus_if.rd_valid}, 32'd1);
        run_to_done(1'b1);
        drain();

        // Masked trigger on value A.
        bus_if.trig_mask  = 4'hF;
        bus_if.trig_value = 4'hA;
        set_in(1'b1, 4'h0, 1'b0);
        tick();
        for (int k = 0; k < 4; k++) begin
            set_in(1'b0, seq[k], 1'b0);
            tick();
        end
        for (int k = 0; k < 6; k++) begin
            set_in(1'b0, 4'($urandom), 1'b0);
            tick();
        end
        check("trig_byte", {24'd0, bus_if.rd_data[7:0]}, 32'h000000BA);

        // Reset at nibble 3 of word 1, then a clean run.
        for (int k = 0; k < 3; k++) begin
            set_in(1'b0, 4'($urandom), 1'b0);
            tick();
        end
        resetn = 1'b0;
        set_in(1'b0, 4'($urandom), 1'b0);
        tick();
        check("rst_mid_state", {30'd0, bus_if.state}, 32'd0);
        check("rst_mid_valid", {31'd0, bus_if.rd_valid}, 32'd0);
        resetn = 1'b1;
        bus_if.trig_mask = 4'h0;
        set_in(1'b1, 4'h0, 1'b0);
        tick();
        run_to_done(1'b1);
        drain();

        // Random traffic with occasional arms and resets.
        for (int i = 0; i < 3000; i++) begin
            resetn            = ($urandom_range(0, 199) != 0);
            bus_if.trig_mask  = 4'($urandom);
            bus_if.trig_value = 4'($urandom);
            set_in($urandom_range(0, 7) == 0, 4'($urandom), 1'($urandom));
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/out_pass4_capture.md
OUT_PASS4_CAPTURE -- requirements
Module: out_pass4_capture

Interface
REQ-001 Parameter CAPTURE_WORDS, default 16: 32-bit words captured per armed run; range 1..65535.
REQ-002 Parameter FIFO_DEPTH, default 4: readback FIFO entries; power of two, at least 2.
REQ-003 UserCLK  input  1  fabric user clock, the same clock that drives the output-pass flops; all logic rising-edge.
REQ-004 resetn  input  1  reset, synchronous, active-low; sampled on the UserCLK rising edge.
REQ-005 I0, I1, I2, I3  input  1 each  output-pass stage outputs O0..O3; nibble N = {I3,I2,I1,I0}.
REQ-006 arm  input  1  single-cycle arm/re-arm request.
REQ-007 trig_value  input  4  trigger compare value.
REQ-008 trig_mask  input  4  trigger compare mask; bit=1 means the bit is compared.
REQ-009 rd_data  output  32  FIFO head word.
REQ-010 rd_valid  output  1  FIFO not empty.
REQ-011 rd_ready  input  1  host accepts rd_data.
REQ-012 state  output  2  FSM state: 0=IDLE, 1=ARMED, 2=CAPTURE, 3=DONE.
REQ-013 done  output  1  high in DONE.
REQ-014 overflow  output  1  sticky: a word was dropped on a full FIFO.

Function
REQ-015 IDLE: arm=1 -> ARMED on the next edge; otherwise stay in IDLE.
REQ-016 ARMED: the trigger hits when (N & trig_mask) == (trig_value & trig_mask); mask 0 hits on the first ARMED cycle.
REQ-017 Trigger hit: next state CAPTURE; the hitting nibble is nibble 0 of word 0 (zero-cycle trigger latency).
REQ-018 CAPTURE: one nibble per cycle; nibble k of a word fills bits [4k+3:4k], k=0..7.
REQ-019 Nibble 7 edge: write {n7..n0} to the FIFO on that same edge; reset the nibble index to 0; increment the word count.
REQ-020 Word count reaching CAPTURE_WORDS at a write: next state DONE; no further nibbles are taken.
REQ-021 Write with the FIFO full and no pop on the same edge: drop the word, set overflow, and still increment the word count.
REQ-022 Write and pop on the same edge with the FIFO full: the write succeeds and overflow is not set.
REQ-023 Pop when rd_valid & rd_ready; rd_valid = (count != 0); rd_data is the head word and stays stable while rd_valid & !rd_ready.
REQ-024 rd_ready while empty: no effect; no pointer underflow.
REQ-025 Latency: a word written on edge t is visible on rd_data/rd_valid after edge t when the FIFO was empty.
REQ-026 Pointers wrap modulo FIFO_DEPTH; the occupancy counter is log2(FIFO_DEPTH)+1 bits.
REQ-027 DONE: done=1; the FIFO stays readable; arm=1 -> ARMED and clears done, overflow, word count and nibble index; FIFO contents are kept.
REQ-028 arm in ARMED or CAPTURE: ignored.
REQ-029 The trigger and capture paths sample I0..I3 directly; no extra input register.

Reset
REQ-030 With resetn=0 at an edge: state=IDLE, done=0, overflow=0, FIFO empty (rd_valid=0), pointers 0, word count 0, nibble index 0.
REQ-031 rd_data resets to 32'h0.
REQ-032 Reset mid-CAPTURE aborts the run; any partial word is discarded.

Verification
REQ-033 Reset, arm, mask=4'h0, drive N=0..7 on consecutive cycles -> rd_data=32'h76543210, rd_valid high one edge after N=7.
REQ-034 mask=4'hF, value=4'hA, stream 3,5,A,B,... -> capture starts at A; word 0 bits [7:0]=8'hBA.
REQ-035 CAPTURE_WORDS=6, FIFO_DEPTH=4, rd_ready=0 -> 4 words stored, overflow=1, done=1 after word 6; drain -> 4 words in order, then rd_valid=0.
REQ-036 FIFO full, rd_ready=1 on the write edge -> no overflow; occupancy stays 4.
REQ-037 resetn=0 at nibble 3 of word 1 -> state=0, rd_valid=0; re-arm and complete a run -> no stale data returned.
REQ-038 In DONE, arm pulse -> state=1, done=0, overflow=0, FIFO words still readable.
